// File: rtl/desequentializer_mono8_if.sv
// Control and AXI-Stream signal bundle for the Mono8 8->256 re-packer.
// The slave modport is the packer's view; the master modport is the view of whoever drives it.
interface desequentializer_mono8_if;
    logic         ap_start;
    logic         ap_idle;
    logic         ap_done;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [7:0]   s_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tlast;

    modport slave (
        input  ap_start,
        output ap_idle,
        output ap_done,
        input  s_axis_tvalid,
        output s_axis_tready,
        input  s_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tdata,
        output m_axis_tkeep,
        output m_axis_tlast
    );

    modport master (
        output ap_start,
        input  ap_idle,
        input  ap_done,
        output s_axis_tvalid,
        input  s_axis_tready,
        output s_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tkeep,
        input  m_axis_tlast
    );
endinterface

// File: rtl/desequentializer_mono8.sv
// Packs a serial Mono8 pixel stream into 256-bit beats of 32 pixels, one frame per ap_start.
// The final beat of a frame is zero-padded, marked in tkeep and flagged with tlast.
module desequentializer_mono8 #(
    parameter int unsigned OUT_ROWS         = 20,
    parameter int unsigned OUT_COLS         = 20,
    parameter int unsigned PIXELS_PER_BURST = 32
) (
    input logic                    clk,
    input logic                    reset,
    desequentializer_mono8_if.slave bus_io
);

    localparam int unsigned NumPix = OUT_ROWS * OUT_COLS;
    localparam int unsigned PixW   = $clog2(NumPix + 1);
    localparam logic [PixW-1:0] LastPix = PixW'(NumPix - 1);

    generate
        if (PIXELS_PER_BURST != 32) begin : g_bad_burst
            $error("PIXELS_PER_BURST must be 32 (256-bit beat of 8-bit pixels)");
        end
        if (NumPix < 1) begin : g_bad_size
            $error("frame must contain at least one pixel");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StSend
    } state_e;

    state_e           state_q, state_d;
    logic [4:0]       lane_q, lane_d;
    logic [PixW-1:0]  pix_q, pix_d;
    logic [31:0][7:0] pack_q, pack_d;
    logic [31:0]      keep_q, keep_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    logic s_hs;
    logic m_hs;

    assign s_hs = (state_q == StFill) && bus_io.s_axis_tvalid;
    assign m_hs = (state_q == StSend) && bus_io.m_axis_tready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.ap_start) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (s_hs && ((lane_q == 5'd31) || (pix_q == LastPix))) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (m_hs) begin
                    state_d = last_q ? StIdle : StFill;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pack register, lane/pixel counters and frame flags
    always_comb begin
        lane_d = lane_q;
        pix_d  = pix_q;
        pack_d = pack_q;
        keep_d = keep_q;
        last_d = last_q;
        done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.ap_start) begin
                    lane_d = '0;
                    pix_d  = '0;
                    pack_d = '0;
                    keep_d = '0;
                    last_d = 1'b0;
                end
            end
            StFill: begin
                if (s_hs) begin
                    pack_d[lane_q] = bus_io.s_axis_tdata;
                    keep_d[lane_q] = 1'b1;
                    lane_d         = lane_q + 5'd1;
                    pix_d          = pix_q + PixW'(1);
                    if (pix_q == LastPix) begin
                        last_d = 1'b1;
                    end
                end
            end
            StSend: begin
                // Clearing after every beat keeps padding lanes at zero and drops tlast in IDLE.
                if (m_hs) begin
                    lane_d = '0;
                    pack_d = '0;
                    keep_d = '0;
                    last_d = 1'b0;
                    done_d = last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            pix_q  <= '0;
            pack_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            pix_q  <= pix_d;
            pack_q <= pack_d;
            keep_q <= keep_d;
            last_q <= last_d;
            done_q <= done_d;
        end
    end

    // Outputs
    always_comb begin
        bus_io.ap_idle       = (state_q == StIdle);
        bus_io.ap_done       = done_q;
        bus_io.s_axis_tready = (state_q == StFill);
        bus_io.m_axis_tvalid = (state_q == StSend);
        bus_io.m_axis_tdata  = pack_q;
        bus_io.m_axis_tkeep  = keep_q;
        bus_io.m_axis_tlast  = last_q;
    end

endmodule

// File: tb/tb_desequentializer_mono8.sv
// Bench for desequentializer_mono8: three frame geometries (20x20, 8x32, 1x1) share one stimulus
// path; a frame-level beat model is compared against the selected instance every cycle.
module tb_desequentializer_mono8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    int         sel = 0;
    logic       s_tvalid = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       m_tready = 1'b1;
    logic       rnd_ready = 1'b0;

    always #5 clk = ~clk;

    desequentializer_mono8_if if_a ();
    desequentializer_mono8_if if_b ();
    desequentializer_mono8_if if_c ();

    assign if_a.ap_start      = start && (sel == 0);
    assign if_a.s_axis_tvalid = s_tvalid;
    assign if_a.s_axis_tdata  = s_tdata;
    assign if_a.m_axis_tready = m_tready;
    assign if_b.ap_start      = start && (sel == 1);
    assign if_b.s_axis_tvalid = s_tvalid;
    assign if_b.s_axis_tdata  = s_tdata;
    assign if_b.m_axis_tready = m_tready;
    assign if_c.ap_start      = start && (sel == 2);
    assign if_c.s_axis_tvalid = s_tvalid;
    assign if_c.s_axis_tdata  = s_tdata;
    assign if_c.m_axis_tready = m_tready;

    desequentializer_mono8 #(.OUT_ROWS(20), .OUT_COLS(20), .PIXELS_PER_BURST(32)) u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .bus_io (if_a)
    );
    desequentializer_mono8 #(.OUT_ROWS(8), .OUT_COLS(32), .PIXELS_PER_BURST(32)) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .bus_io (if_b)
    );
    desequentializer_mono8 #(.OUT_ROWS(1), .OUT_COLS(1), .PIXELS_PER_BURST(32)) u_dut_c (
        .clk    (clk),
        .reset  (reset),
        .bus_io (if_c)
    );

    logic         mx_idle, mx_done, mx_sready, mx_mvalid, mx_last;
    logic [255:0] mx_data;
    logic [31:0]  mx_keep;

    always_comb begin
        mx_idle = if_a.ap_idle;  mx_done = if_a.ap_done;  mx_sready = if_a.s_axis_tready;
        mx_mvalid = if_a.m_axis_tvalid;  mx_data = if_a.m_axis_tdata;
        mx_keep = if_a.m_axis_tkeep;  mx_last = if_a.m_axis_tlast;
        if (sel == 1) begin
            mx_idle = if_b.ap_idle;  mx_done = if_b.ap_done;  mx_sready = if_b.s_axis_tready;
            mx_mvalid = if_b.m_axis_tvalid;  mx_data = if_b.m_axis_tdata;
            mx_keep = if_b.m_axis_tkeep;  mx_last = if_b.m_axis_tlast;
        end else if (sel == 2) begin
            mx_idle = if_c.ap_idle;  mx_done = if_c.ap_done;  mx_sready = if_c.s_axis_tready;
            mx_mvalid = if_c.m_axis_tvalid;  mx_data = if_c.m_axis_tdata;
            mx_keep = if_c.m_axis_tkeep;  mx_last = if_c.m_axis_tlast;
        end
    end

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    beat_t exp_q[$];
    beat_t cap[$];
    beat_t held;
    beat_t exp_b;
    logic  hold = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    done_cnt = 0;

    localparam logic [255:0] Lit0 =
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [255:0] Lit12 =
        256'h000000000000000000000000000000008f8e8d8c8b8a89888786858483828180;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Frame model: pixel i of a frame lands in beat i/32, lane i%32; the last beat carries tlast.
    task automatic build_frame(input int n, input int base);
        int    nb;
        beat_t b;
        nb = (n + 31) / 32;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int ln = 0; ln < 32; ln++) begin
                if (bi * 32 + ln < n) begin
                    b.d[8*ln +: 8] = 8'((base + bi * 32 + ln) % 256);
                    b.k[ln]        = 1'b1;
                end
            end
            b.l = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            chk("ready_valid_excl", 256'(mx_sready & mx_mvalid), 256'd0);
            if (hold) begin
                chk("hold_valid", 256'(mx_mvalid), 256'd1);
                chk("hold_data", mx_data, held.d);
                chk("hold_keep", 256'(mx_keep), 256'(held.k));
                chk("hold_last", 256'(mx_last), 256'(held.l));
            end
            hold = mx_mvalid && !m_tready;
            held = {mx_data, mx_keep, mx_last};
            if (mx_mvalid && m_tready) begin
                cap.push_back({mx_data, mx_keep, mx_last});
                chk("beat_expected", 256'(exp_q.size() != 0), 256'd1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    chk("beat_data", mx_data, exp_b.d);
                    chk("beat_keep", 256'(mx_keep), 256'(exp_b.k));
                    chk("beat_last", 256'(mx_last), 256'(exp_b.l));
                end
            end
            if (mx_done) begin
                done_cnt++;
                chk("done_after_last", 256'(exp_q.size()), 256'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixel(input logic [7:0] d, input int gap_pct);
        int guard;
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            s_tvalid = 1'b0;
            tick();
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        guard    = 0;
        @(negedge clk);
        while (!mx_sready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("s_ready_timeout", 256'(mx_sready), 256'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_idle", 256'(mx_idle), 256'd1);
        chk("rst_done", 256'(mx_done), 256'd0);
        chk("rst_sready", 256'(mx_sready), 256'd0);
        chk("rst_mvalid", 256'(mx_mvalid), 256'd0);
        chk("rst_last", 256'(mx_last), 256'd0);
        chk("rst_data", mx_data, 256'd0);
        chk("rst_keep", 256'(mx_keep), 256'd0);
    endtask

    task automatic run_frame(input int s, input int n, input int base, input int gap);
        int d0;
        int g;
        d0  = done_cnt;
        sel = s;
        cap.delete();
        build_frame(n, base);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) push_pixel(8'((base + i) % 256), gap);
        g = 0;
        while (done_cnt == d0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        repeat (20) tick();
        chk("single_done", 256'(done_cnt - d0), 256'd1);
        chk("queue_drained", 256'(exp_q.size()), 256'd0);
        chk("beat_count", 256'(cap.size()), 256'((n + 31) / 32));
        chk("idle_after", 256'(mx_idle), 256'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Pin the model against hand-computed beats for the 20x20 ramp
        build_frame(400, 0);
        chk("model_beats", 256'(exp_q.size()), 256'd13);
        chk("model_b0", exp_q[0].d, Lit0);
        chk("model_b12", exp_q[12].d, Lit12);
        chk("model_k12", 256'(exp_q[12].k), 256'h0000ffff);
        chk("model_l11", 256'(exp_q[11].l), 256'd0);
        exp_q.delete();

        // 20x20 ramp, tready held high
        run_frame(0, 400, 0, 0);
        chk("b0_data", cap[0].d, Lit0);
        chk("b0_last", 256'(cap[0].l), 256'd0);
        chk("b12_data", cap[12].d, Lit12);
        chk("b12_keep", 256'(cap[12].k), 256'h0000ffff);
        chk("b12_last", 256'(cap[12].l), 256'd1);

        // 8x32: exact multiple of 32, no padding
        run_frame(1, 256, 0, 0);
        chk("n256_k7", 256'(cap[7].k), 256'hffffffff);
        chk("n256_l7", 256'(cap[7].l), 256'd1);
        chk("n256_top", 256'(cap[7].d[255:248]), 256'hff);

        // Random backpressure and input gaps
        rnd_ready = 1'b1;
        run_frame(0, 400, 100, 30);
        rnd_ready = 1'b0;
        tick();
        m_tready = 1'b1;

        // Reset after 50 pixels: pending partial beat dropped, nothing emitted afterwards
        sel = 0;
        build_frame(400, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) push_pixel(8'(i), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        repeat (40) tick();
        chk("no_emit_after_rst", 256'(mx_idle), 256'd1);
        run_frame(0, 400, 7, 0);
        chk("rst_next_lane0", 256'(cap[0].d[15:0]), 256'h0807);

        // ap_start pulsed in FILL and in a stalled SEND must be ignored
        m_tready = 1'b0;
        fork
            run_frame(0, 400, 3, 0);
            begin
                int g;
                repeat (10) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
                g = 0;
                @(negedge clk);
                while (!mx_mvalid && g < 500) begin
                    @(negedge clk);
                    g++;
                end
                chk("send_reached", 256'(mx_mvalid), 256'd1);
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                tick();
                m_tready = 1'b1;
            end
        join

        // 1x1 frame: a single one-pixel beat
        run_frame(2, 1, 8'ha5, 0);
        chk("n1_data", cap[0].d, 256'ha5);
        chk("n1_keep", 256'(cap[0].k), 256'h1);
        chk("n1_last", 256'(cap[0].l), 256'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
